// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: start after reset, hold PC on stalls, redirect on taken
// branches with an IF/ID flush window, and stop permanently on a HALT opcode.
module fetch_controller #(
   parameter int                    PC_WIDTH          = 32,
   parameter int                    INSTRUCTION_WIDTH = 30,
   parameter int                    OPCODE_WIDTH      = 4,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE     = 4'hF,
   parameter int                    FLUSH_CYCLES      = 2,
   parameter int                    COUNT_WIDTH       = 32
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   input  logic                         start_i,
   input  logic                         stall_i,
   input  logic                         branch_taken_i,
   input  logic [PC_WIDTH-1:0]          branch_target_i,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction_i,
   output logic                         pc_enable_o,
   output logic                         pc_selector_o,
   output logic [PC_WIDTH-1:0]          new_pc_o,
   output logic                         flush_ifid_o,
   output logic                         valid_if_o,
   output logic                         halted_o,
   output logic [COUNT_WIDTH-1:0]       fetch_count_o
);

   // state    | meaning
   // IDLE     | waiting for start, fetch disabled
   // RUN      | issuing instructions, honouring stall / branch / halt
   // REDIRECT | squashing younger work after a taken branch
   // HALT     | fetch stopped until reset
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       redir_cnt_q, redir_cnt_d;
   logic                   halted_q, halted_d;
   logic [COUNT_WIDTH-1:0] fetch_count_q, fetch_count_d;
   logic [OPCODE_WIDTH-1:0] opcode;

   assign opcode = instruction_i[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         redir_cnt_q   <= '0;
         halted_q      <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         redir_cnt_q   <= redir_cnt_d;
         halted_q      <= halted_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      redir_cnt_d   = redir_cnt_q;
      halted_d      = halted_q;
      fetch_count_d = fetch_count_q;
      pc_enable_o   = 1'b0;
      pc_selector_o = 1'b0;
      new_pc_o      = '0;
      flush_ifid_o  = 1'b0;
      valid_if_o    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (branch_taken_i) begin
               pc_enable_o   = 1'b1;
               pc_selector_o = 1'b1;
               new_pc_o      = branch_target_i;
               flush_ifid_o  = 1'b1;
               if (FLUSH_CYCLES == 1) begin
                  state_d = ST_RUN;
               end else begin
                  state_d     = ST_REDIRECT;
                  redir_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
               end
            end else if (opcode == HALT_OPCODE) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end else if (stall_i) begin
               valid_if_o = 1'b1;
            end else begin
               pc_enable_o   = 1'b1;
               valid_if_o    = 1'b1;
               fetch_count_d = fetch_count_q + COUNT_WIDTH'(1);
            end
         end
         ST_REDIRECT: begin
            // Counter is loaded with the number of REDIRECT cycles still owed;
            // leave on the cycle it holds the last one.
            flush_ifid_o = 1'b1;
            if (redir_cnt_q <= CNT_W'(1)) begin
               state_d     = ST_RUN;
               redir_cnt_d = '0;
            end else begin
               redir_cnt_d = redir_cnt_q - CNT_W'(1);
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign halted_o      = halted_q;
   assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: three parameterisations driven in lockstep and
// compared every cycle against a behavioural model of the sequencing rules.
module tb_fetch_controller;

   localparam int N = 3;
   localparam logic [N-1:0][7:0] FCP = {8'd3, 8'd1, 8'd2};
   localparam logic [N-1:0][7:0] CWP = {8'd4, 8'd4, 8'd32};

   logic        clock;
   logic        reset;
   logic        start;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [29:0] instruction;

   logic        pc_en   [N];
   logic        pc_sel  [N];
   logic [31:0] new_pc  [N];
   logic        flush   [N];
   logic        valid   [N];
   logic        halted  [N];
   logic [31:0] fcount  [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int FC = int'(FCP[g]);
      localparam int CW = int'(CWP[g]);
      logic          en_l, sel_l, fl_l, v_l, h_l;
      logic [31:0]   np_l;
      logic [CW-1:0] fc_l;

      fetch_controller #(
         .PC_WIDTH(32), .INSTRUCTION_WIDTH(30), .OPCODE_WIDTH(4),
         .HALT_OPCODE(4'hF), .FLUSH_CYCLES(FC), .COUNT_WIDTH(CW)
      ) dut (
         .clock_i         (clock),
         .reset_i         (reset),
         .start_i         (start),
         .stall_i         (stall),
         .branch_taken_i  (branch_taken),
         .branch_target_i (branch_target),
         .instruction_i   (instruction),
         .pc_enable_o     (en_l),
         .pc_selector_o   (sel_l),
         .new_pc_o        (np_l),
         .flush_ifid_o    (fl_l),
         .valid_if_o      (v_l),
         .halted_o        (h_l),
         .fetch_count_o   (fc_l)
      );

      assign pc_en[g]  = en_l;
      assign pc_sel[g] = sel_l;
      assign new_pc[g] = np_l;
      assign flush[g]  = fl_l;
      assign valid[g]  = v_l;
      assign halted[g] = h_l;
      assign fcount[g] = 32'(fc_l);
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned total  = 0;
   int unsigned passed = 0;

   // Model: has the core been started, is it halted, how many flush cycles
   // are still owed after a branch, and how many instructions were issued.
   bit     m_run  [N];
   bit     m_halt [N];
   int     m_owe  [N];
   longint m_cnt  [N];

   task automatic check(input string tag, input int inst,
                        input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_run[i] = 0; m_halt[i] = 0; m_owe[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic step(input bit r, input bit s, input bit st, input bit b,
                       input logic [31:0] t, input logic [29:0] ins);
      bit          is_halt;
      bit          e_en, e_sel, e_fl, e_v;
      logic [31:0] e_np;
      @(negedge clock);
      reset = r; start = s; stall = st; branch_taken = b;
      branch_target = t; instruction = ins;
      is_halt = (ins[29:26] == 4'hF);
      #1;
      for (int i = 0; i < N; i++) begin
         e_en = 0; e_sel = 0; e_fl = 0; e_v = 0; e_np = '0;
         if (m_run[i] && !m_halt[i]) begin
            if (m_owe[i] > 0) e_fl = 1;
            else if (b) begin e_en = 1; e_sel = 1; e_np = t; e_fl = 1; end
            else if (is_halt) begin end
            else if (st) e_v = 1;
            else begin e_en = 1; e_v = 1; end
         end
         check("pcEnable",   i, 32'(pc_en[i]),  32'(e_en));
         check("pcSelector", i, 32'(pc_sel[i]), 32'(e_sel));
         check("newPC",      i, new_pc[i],      e_np);
         check("flushIFID",  i, 32'(flush[i]),  32'(e_fl));
         check("validIF",    i, 32'(valid[i]),  32'(e_v));
         check("halted",     i, 32'(halted[i]), 32'(m_halt[i]));
         check("fetchCount", i, fcount[i],      32'(m_cnt[i]));
      end
      @(posedge clock);
      if (r) model_reset();
      else begin
         for (int i = 0; i < N; i++) begin
            if (m_halt[i]) begin end
            else if (!m_run[i]) begin if (s) m_run[i] = 1; end
            else if (m_owe[i] > 0) m_owe[i]--;
            else if (b) m_owe[i] = int'(FCP[i]) - 1;
            else if (is_halt) m_halt[i] = 1;
            else if (!st) m_cnt[i] = (m_cnt[i] + 1) % (64'd1 << int'(CWP[i]));
         end
      end
   endtask

   localparam logic [29:0] NOP  = 30'h0001234;
   localparam logic [29:0] HALT = {4'hF, 26'h0};

   initial begin
      logic [29:0] ins;
      bit r, s, st, b;
      reset = 1; start = 0; stall = 0; branch_taken = 0;
      branch_target = '0; instruction = NOP;
      @(posedge clock);
      model_reset();

      // startup and free run
      step(1, 0, 0, 0, 32'h0, NOP);
      step(1, 0, 0, 0, 32'h0, NOP);
      step(0, 1, 0, 0, 32'h0, NOP);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 32'h0, NOP);
      // stall window
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 32'h0, NOP);
      step(0, 0, 0, 0, 32'h0, NOP);
      // redirect
      step(0, 0, 0, 1, 32'h40, NOP);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 32'h0, NOP);
      // priority: branch beats halt and stall, branch in REDIRECT ignored
      step(0, 0, 1, 1, 32'h80, HALT);
      step(0, 0, 1, 1, 32'h90, HALT);
      step(0, 0, 0, 0, 32'h0, NOP);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 32'h0, NOP);
      // halt is sticky through start and branch
      step(0, 0, 0, 0, 32'h0, HALT);
      step(0, 1, 0, 0, 32'h0, NOP);
      step(0, 0, 0, 1, 32'h44, NOP);
      step(1, 0, 0, 0, 32'h0, NOP);
      step(0, 0, 0, 0, 32'h0, NOP);
      // reset during REDIRECT
      step(0, 1, 0, 0, 32'h0, NOP);
      step(0, 0, 0, 1, 32'h100, NOP);
      step(1, 0, 0, 0, 32'h0, NOP);
      step(0, 0, 0, 0, 32'h0, NOP);
      // counter wrap on the 4-bit instances
      step(0, 1, 0, 0, 32'h0, NOP);
      for (int k = 0; k < 17; k++) step(0, 0, 0, 0, 32'h0, NOP);
      step(0, 0, 1, 0, 32'h0, NOP);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         r  = ($urandom_range(99) < 3);
         s  = ($urandom_range(99) < 40);
         st = ($urandom_range(99) < 30);
         b  = ($urandom_range(99) < 15);
         ins = 30'($urandom);
         if ($urandom_range(99) < 4) ins[29:26] = 4'hF;
         else if (ins[29:26] == 4'hF) ins[29] = 1'b0;
         step(r, s, st, b, $urandom, ins);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
